// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-port RAM arbiter: default geometry and FSM states.
package ram_arbiter_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADR_W_DEF  = 3;

    typedef enum logic {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin grant decision with its priority pointer.
// Grants are combinational; the pointer moves to the losing side after each grant.
module rr_pick2 (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    // prio = 0 favours requester 0 on a tie, prio = 1 favours requester 1
    logic prio;

    // Pick at most one requester; tie broken by the pointer
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (en) begin
            if (req0 && (!req1 || !prio)) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
    end

    // Hand priority to the other requester after every grant; hold when idle
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= 1'b0;
        end else if (gnt0) begin
            prio <= 1'b1;
        end else if (gnt1) begin
            prio <= 1'b0;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates two requesters onto one single-port RAM with registered read data,
// and runs a clear sweep that writes zero to every address on request.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADR_W  = ADR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADR_W-1:0]  adr0,
    input  logic [ADR_W-1:0]  adr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              ram_w,
    output logic [ADR_W-1:0]  ram_adr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam logic [ADR_W-1:0] LAST_ADR = '1;

    state_t            state;
    logic [ADR_W-1:0]  sweep_cnt;
    logic [ADR_W-1:0]  adr_q;
    logic [DATA_W-1:0] din_q;
    logic              gnt0;
    logic              gnt1;

    rr_pick2 u_pick (
        .clk  (clk),
        .rst  (rst),
        .en   ((state == ARB) && !rst),
        .req0 (req0),
        .req1 (req1),
        .gnt0 (gnt0),
        .gnt1 (gnt1)
    );

    assign ack0  = gnt0;
    assign ack1  = gnt1;
    assign rdata = ram_dout;

    // RAM command: sweep in CLEAR, winner's access in ARB, otherwise hold the last address/data
    // NOTE: every output gets a default first, so the "hold" comes from adr_q/din_q flops, not a latch.
    always_comb begin
        ram_w   = 1'b0;
        ram_adr = adr_q;
        ram_din = din_q;
        if (rst) begin
            ram_adr = '0;
            ram_din = '0;
        end else if (state == CLEAR) begin
            ram_w   = 1'b1;
            ram_adr = sweep_cnt;
            ram_din = '0;
        end else if (gnt0) begin
            ram_w   = we0;
            ram_adr = adr0;
            ram_din = wdata0;
        end else if (gnt1) begin
            ram_w   = we1;
            ram_adr = adr1;
            ram_din = wdata1;
        end
    end

    // FSM, sweep counter, held command fields and one-cycle-late read-valid pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB;
            sweep_cnt <= '0;
            adr_q     <= '0;
            din_q     <= '0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            clr_busy  <= 1'b0;
        end else begin
            adr_q   <= ram_adr;
            din_q   <= ram_din;
            // The RAM returns data one cycle after the read command, so valid follows the grant
            rvalid0 <= gnt0 && !we0;
            rvalid1 <= gnt1 && !we1;
            case (state)
                ARB: begin
                    if (clr_req) begin
                        state     <= CLEAR;
                        sweep_cnt <= '0;
                        clr_busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (sweep_cnt == LAST_ADR) begin
                        state    <= ARB;
                        clr_busy <= 1'b0;
                    end else begin
                        sweep_cnt <= sweep_cnt + 1'b1;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural registered-read RAM attached.
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, we0, we1;
    logic [2:0] adr0, adr1;
    logic [7:0] wdata0, wdata1;
    logic       ack0, ack1, rvalid0, rvalid1;
    logic [7:0] rdata;
    logic       clr_req, clr_busy;
    logic       ram_w;
    logic [2:0] ram_adr;
    logic [7:0] ram_din;
    logic [7:0] ram_dout;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mem [8];

    ram_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .req1     (req1),
        .we0      (we0),
        .we1      (we1),
        .adr0     (adr0),
        .adr1     (adr1),
        .wdata0   (wdata0),
        .wdata1   (wdata1),
        .ack0     (ack0),
        .ack1     (ack1),
        .rvalid0  (rvalid0),
        .rvalid1  (rvalid1),
        .rdata    (rdata),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .ram_w    (ram_w),
        .ram_adr  (ram_adr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: synchronous write, registered read (old data on same-address write)
    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 8'h10 + 8'(i);
        ram_dout = 8'h00;
    end

    always @(posedge clk) begin
        if (ram_w) mem[ram_adr] <= ram_din;
        ram_dout <= mem[ram_adr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled mid-cycle
    task automatic mid();
        @(negedge clk);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        adr0 = '0; adr1 = '0; wdata0 = '0; wdata1 = '0;
        clr_req = 1'b0;

        // Reset state, with a requester active to show acks are suppressed
        next();
        req0 = 1'b1;
        mid();
        check("rst_ack0", ack0, 0);
        check("rst_ack1", ack1, 0);
        check("rst_rvalid0", rvalid0, 0);
        check("rst_rvalid1", rvalid1, 0);
        check("rst_clr_busy", clr_busy, 0);
        check("rst_ram_w", ram_w, 0);
        check("rst_ram_adr", ram_adr, 0);
        check("rst_ram_din", ram_din, 0);
        next();
        rst = 1'b0;

        // Both read continuously from reset: grants alternate 0,1,0,1
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; adr0 = 3'd1; adr1 = 3'd2;
        for (int k = 0; k < 4; k++) begin
            mid();
            check("rr_ack0", ack0, (k % 2 == 0));
            check("rr_ack1", ack1, (k % 2 == 1));
            check("rr_adr", ram_adr, (k % 2 == 0) ? 1 : 2);
            if (k > 0) begin
                check("rr_rvalid0", rvalid0, (k % 2 == 1));
                check("rr_rvalid1", rvalid1, (k % 2 == 0));
                check("rr_rdata", rdata, (k % 2 == 1) ? 8'h11 : 8'h12);
            end
            next();
        end
        req0 = 1'b0; req1 = 1'b0;
        mid();
        check("idle_ack0", ack0, 0);
        check("idle_ack1", ack1, 0);
        check("idle_ram_w", ram_w, 0);
        check("idle_adr_hold", ram_adr, 2);
        check("idle_rvalid1", rvalid1, 1);
        check("idle_rvalid0", rvalid0, 0);
        check("idle_rdata", rdata, 8'h12);
        next();

        // req0 write adr 3 = A5, then read it back
        req0 = 1'b1; we0 = 1'b1; adr0 = 3'd3; wdata0 = 8'hA5;
        mid();
        check("wr3_ack0", ack0, 1);
        check("wr3_ram_w", ram_w, 1);
        check("wr3_ram_adr", ram_adr, 3);
        check("wr3_ram_din", ram_din, 8'hA5);
        next();
        we0 = 1'b0;
        mid();
        check("rd3_ack0", ack0, 1);
        check("rd3_ram_w", ram_w, 0);
        check("rd3_rvalid0_early", rvalid0, 0);
        next();
        req0 = 1'b0;
        mid();
        check("rd3_rvalid0", rvalid0, 1);
        check("rd3_rvalid1", rvalid1, 0);
        check("rd3_rdata", rdata, 8'hA5);
        check("rd3_din_hold", ram_din, 8'hA5);
        next();

        // req1 write adr 5 = 3C, read adr 5 the very next cycle
        req1 = 1'b1; we1 = 1'b1; adr1 = 3'd5; wdata1 = 8'h3C;
        mid();
        check("wr5_ack1", ack1, 1);
        check("wr5_ram_w", ram_w, 1);
        next();
        we1 = 1'b0;
        mid();
        check("rd5_ack1", ack1, 1);
        check("rd5_ram_adr", ram_adr, 5);
        next();
        req1 = 1'b0;
        mid();
        check("rd5_rvalid1", rvalid1, 1);
        check("rd5_rdata", rdata, 8'h3C);
        next();

        // Fill every address with FF
        req0 = 1'b1; we0 = 1'b1; wdata0 = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            adr0 = 3'(i);
            mid();
            check("fill_ack0", ack0, 1);
            next();
        end
        req0 = 1'b0; we0 = 1'b0;

        // clr_req together with a read grant: the grant still completes
        clr_req = 1'b1; req1 = 1'b1; we1 = 1'b0; adr1 = 3'd7;
        mid();
        check("clr_same_cycle_ack1", ack1, 1);
        check("clr_same_cycle_busy", clr_busy, 0);
        next();
        for (int j = 0; j < 8; j++) begin
            clr_req = (j == 3);
            mid();
            check("sweep_busy", clr_busy, 1);
            check("sweep_ram_w", ram_w, 1);
            check("sweep_ram_adr", ram_adr, j);
            check("sweep_ram_din", ram_din, 0);
            check("sweep_ack1", ack1, 0);
            check("sweep_rvalid1", rvalid1, (j == 0));
            if (j == 0) check("sweep_pending_rdata", rdata, 8'hFF);
            next();
        end
        clr_req = 1'b0;
        mid();
        check("post_sweep_busy", clr_busy, 0);
        check("post_sweep_ack1", ack1, 1);
        check("post_sweep_ram_w", ram_w, 0);
        check("post_sweep_ram_adr", ram_adr, 7);
        next();
        req1 = 1'b0; req0 = 1'b1; we0 = 1'b0; adr0 = 3'd0;
        mid();
        check("post_sweep_rvalid1", rvalid1, 1);
        check("post_sweep_rdata7", rdata, 8'h00);
        check("post_sweep_ack0", ack0, 1);
        next();
        req0 = 1'b0;
        mid();
        check("post_sweep_rvalid0", rvalid0, 1);
        check("post_sweep_rdata0", rdata, 8'h00);
        next();

        // Reset on the 4th sweep cycle aborts CLEAR and restores prio to 0
        clr_req = 1'b1;
        mid();
        next();
        clr_req = 1'b0;
        for (int j = 0; j < 3; j++) begin
            mid();
            check("abort_sweep_adr", ram_adr, j);
            next();
        end
        rst = 1'b1;
        mid();
        check("abort_rst_ram_w", ram_w, 0);
        check("abort_rst_ram_adr", ram_adr, 0);
        next();
        rst = 1'b0; req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; adr0 = 3'd4; adr1 = 3'd6;
        mid();
        check("abort_busy", clr_busy, 0);
        check("abort_ram_w", ram_w, 0);
        check("abort_prio_ack0", ack0, 1);
        check("abort_prio_ack1", ack1, 0);
        check("abort_ram_adr", ram_adr, 4);
        next();
        req0 = 1'b0; req1 = 1'b0;
        mid();
        check("abort_rvalid0", rvalid0, 1);
        check("abort_rdata", rdata, 8'h00);
        next();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
